// File: rtl/hazard_controller.sv
// hazard_controller: fetch/decode/execute stall/flush sequencer; define HAZARD_PERF_EN to add the stall-cycle counter
module hazard_controller #(
  parameter int AWIDTH       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_LAT     = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic              h_clk,
  input  logic              h_rst,
  input  logic              h_i_id_ce,
  input  logic [AWIDTH-1:0] h_i_id_rs1,
  input  logic [AWIDTH-1:0] h_i_id_rs2,
  input  logic              h_i_ex_ce,
  input  logic [AWIDTH-1:0] h_i_ex_rd,
  input  logic              h_i_ex_load,
  input  logic              h_i_ex_redirect,
  input  logic              h_i_ex_busy,
  input  logic              h_i_halt,
  output logic              h_o_if_stall,
  output logic              h_o_id_stall,
  output logic              h_o_id_flush,
  output logic              h_o_ex_flush,
`ifdef HAZARD_PERF_EN
  input  logic                 h_i_cnt_clr,
  output logic [CNT_WIDTH-1:0] h_o_stall_cnt,
`endif
  output logic [2:0]        h_o_state
);
  localparam int MAXC = FLUSH_CYCLES > LOAD_LAT ? FLUSH_CYCLES : LOAD_LAT;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] FC_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] LL_LOAD = CW'(LOAD_LAT - 1);
  typedef enum logic [2:0] {RUN = 3'd0, LDSTALL = 3'd1, FLUSH = 3'd2, BUSY = 3'd3, HALT = 3'd4} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic ld_use, stall, id_flush, ex_flush;
  assign ld_use = h_i_ex_ce & h_i_ex_load & h_i_id_ce & (h_i_ex_rd != '0) &
                  ((h_i_ex_rd == h_i_id_rs1) | (h_i_ex_rd == h_i_id_rs2));
  always_comb begin
    state_n  = RUN;
    cnt_n    = cnt;
    stall    = 1'b0;
    id_flush = 1'b0;
    ex_flush = 1'b0;
    case (state)
      RUN: begin
        if (h_i_halt) begin
          stall   = 1'b1;
          state_n = HALT;
        end else if (h_i_ex_redirect) begin
          id_flush = 1'b1;
          ex_flush = 1'b1;
          cnt_n    = FC_LOAD;
          state_n  = FLUSH_CYCLES == 1 ? RUN : FLUSH;
        end else if (h_i_ex_busy) begin
          stall   = 1'b1;
          state_n = BUSY;
        end else if (ld_use) begin
          stall    = 1'b1;
          ex_flush = 1'b1;
          cnt_n    = LL_LOAD;
          state_n  = LOAD_LAT == 1 ? RUN : LDSTALL;
        end
      end
      LDSTALL: begin
        if (h_i_ex_redirect) begin
          id_flush = 1'b1;
          ex_flush = 1'b1;
          cnt_n    = FC_LOAD;
          state_n  = FLUSH_CYCLES == 1 ? RUN : FLUSH;
        end else begin
          stall    = 1'b1;
          ex_flush = 1'b1;
          cnt_n    = cnt != '0 ? cnt - CW'(1) : cnt;
          state_n  = cnt <= CW'(1) ? RUN : LDSTALL;
        end
      end
      FLUSH: begin
        id_flush = 1'b1;
        ex_flush = h_i_ex_redirect;
        cnt_n    = h_i_ex_redirect ? FC_LOAD : cnt != '0 ? cnt - CW'(1) : cnt;
        state_n  = h_i_ex_redirect || cnt > CW'(1) ? FLUSH : RUN;
      end
      BUSY: begin
        stall   = h_i_ex_busy;
        state_n = h_i_ex_busy ? BUSY : h_i_halt ? HALT : RUN;
      end
      HALT: begin
        stall   = h_i_halt;
        state_n = h_i_halt ? HALT : RUN;
      end
      default: begin
        id_flush = 1'b1;
        ex_flush = 1'b1;
      end
    endcase
    if (h_rst) begin
      stall    = 1'b0;
      id_flush = 1'b1;
      ex_flush = 1'b1;
    end
  end
  always_ff @(posedge h_clk or posedge h_rst)
    if (h_rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  assign h_o_if_stall = stall;
  assign h_o_id_stall = stall;
  assign h_o_id_flush = id_flush;
  assign h_o_ex_flush = ex_flush;
  assign h_o_state    = state;
`ifdef HAZARD_PERF_EN
  always_ff @(posedge h_clk or posedge h_rst)
    if (h_rst)
      h_o_stall_cnt <= '0;
    else if (h_i_cnt_clr)
      h_o_stall_cnt <= '0;
    else if (stall && !(&h_o_stall_cnt))
      h_o_stall_cnt <= h_o_stall_cnt + CNT_WIDTH'(1);
`endif
endmodule
